// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised single-clock synchronous FIFO. Producer and consumer share one clock.
//   All outputs are registered; status flags are derived from the next-state count, so
//   they change on the same edge as count.
//
// Parameters
//   DATA_W     data width in bits
//   DEPTH      number of entries (power of 2, >= 4)
//   AF_THRESH  almost_full  when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous, active-low reset
//   wr            in   write request; din sampled on the same edge
//   rd            in   read request
//   din           in   write data
//   dout          out  registered read data, valid after the accepting edge
//   full, empty   out  count == DEPTH / count == 0
//   almost_full   out  count >= AF_THRESH
//   almost_empty  out  count <= AE_THRESH
//   count         out  occupancy, 0..DEPTH
//   overflow      out  one-cycle pulse per rejected write
//   underflow     out  one-cycle pulse per rejected read

module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned ADDR_W   = $clog2(DEPTH),
    localparam int unsigned CNT_W    = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  count_d;
    logic              wr_ok;
    logic              rd_ok;

    // At full, a simultaneous read frees the slot; at empty, a read is never accepted.
    always_comb begin
        wr_ok = wr & (~full | rd);
        rd_ok = rd & ~empty;
    end

    always_comb begin
        count_d = count;
        if (wr_ok && !rd_ok) begin
            count_d = count + CNT_W'(1);
        end else if (!wr_ok && rd_ok) begin
            count_d = count - CNT_W'(1);
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            dout         <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                dout <= mem[rptr];
                rptr <= rptr + ADDR_W'(1);
            end
            count        <= count_d;
            full         <= (count_d == CNT_W'(DEPTH));
            empty        <= (count_d == '0);
            almost_full  <= (count_d >= CNT_W'(AF_THRESH));
            almost_empty <= (count_d <= CNT_W'(AE_THRESH));
            overflow     <= wr & full & ~rd;
            underflow    <= rd & empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
//   Self-checking bench for sync_fifo_param (default parameters). A small occupancy model
//   predicts flags and error pulses; a data queue predicts dout. A vector table covers a
//   short mixed sequence around empty, hand-written sequences cover fill, drain, wrap and
//   asynchronous reset.

module tb_sync_fifo_param;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AF  = 14;
    localparam int AE  = 2;

    logic          clk;
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    sync_fifo_param #(
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .rd           (rd),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int            mcount;
    logic [DW-1:0] mdout;
    logic [DW-1:0] sb[$];
    logic          movf;
    logic          mudf;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            exp_count;
        logic          exp_ovf;
        logic          exp_udf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mcount));
        chk({tag, ".full"}, 32'(full), 32'(mcount == DEP));
        chk({tag, ".empty"}, 32'(empty), 32'(mcount == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(mcount >= AF));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(mcount <= AE));
        chk({tag, ".ovf"}, 32'(overflow), 32'(movf));
        chk({tag, ".udf"}, 32'(underflow), 32'(mudf));
        chk({tag, ".dout"}, 32'(dout), 32'(mdout));
    endtask

    function automatic void model_reset();
        mcount = 0;
        mdout  = '0;
        movf   = 1'b0;
        mudf   = 1'b0;
        sb.delete();
    endfunction

    // Called at edge+1: drive, predict from pre-edge model state, clock, check at edge+1.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        logic wok;
        logic rok;
        wr  = w;
        rd  = r;
        din = d;
        wok = w && ((mcount != DEP) || r);
        rok = r && (mcount != 0);
        movf = w && (mcount == DEP) && !r;
        mudf = r && (mcount == 0);
        if (rok) mdout = sb.pop_front();
        if (wok) sb.push_back(d);
        mcount = mcount + int'(wok) - int'(rok);
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        tbl[0] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 0, exp_ovf: 1'b0, exp_udf: 1'b1};
        tbl[1] = '{wr: 1'b1, rd: 1'b1, din: 8'h11, exp_count: 1, exp_ovf: 1'b0, exp_udf: 1'b1};
        tbl[2] = '{wr: 1'b1, rd: 1'b0, din: 8'h22, exp_count: 2, exp_ovf: 1'b0, exp_udf: 1'b0};
        tbl[3] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 1, exp_ovf: 1'b0, exp_udf: 1'b0};
        tbl[4] = '{wr: 1'b1, rd: 1'b1, din: 8'h33, exp_count: 1, exp_ovf: 1'b0, exp_udf: 1'b0};
        tbl[5] = '{wr: 1'b0, rd: 1'b0, din: 8'h44, exp_count: 1, exp_ovf: 1'b0, exp_udf: 1'b0};
        tbl[6] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 0, exp_ovf: 1'b0, exp_udf: 1'b0};
        tbl[7] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 0, exp_ovf: 1'b0, exp_udf: 1'b1};

        rst = 1'b0;
        wr  = 1'b0;
        rd  = 1'b0;
        din = '0;
        model_reset();

        // 1: reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b1;

        // 2: fill 0x01..0x10; flags checked after every edge
        for (int i = 1; i <= DEP; i++) begin
            step(1'b1, 1'b0, 8'(i), "fill");
        end
        chk("fill.full_end", 32'(full), 32'd1);

        // 3: overflow at full, then drain in order
        step(1'b1, 1'b0, 8'hFF, "ovf");
        chk("ovf.pulse", 32'(overflow), 32'd1);
        for (int i = 1; i <= DEP; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            chk("drain.order", 32'(dout), 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // 4: underflow at empty, dout holds; write+read at empty is write only
        step(1'b0, 1'b1, 8'h00, "udf");
        chk("udf.hold", 32'(dout), 32'h10);
        step(1'b1, 1'b1, 8'h77, "udf_wr");
        chk("udf_wr.count", 32'(count), 32'd1);
        step(1'b0, 1'b1, 8'h00, "udf_drain");

        // Vector table from empty
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din, "tbl");
            chk("tbl.count", 32'(count), 32'(tbl[i].exp_count));
            chk("tbl.ovf", 32'(overflow), 32'(tbl[i].exp_ovf));
            chk("tbl.udf", 32'(underflow), 32'(tbl[i].exp_udf));
        end

        // 5: simultaneous read/write at full across pointer wrap, then at count 8
        for (int i = 0; i < DEP; i++) begin
            step(1'b1, 1'b0, 8'(8'h40 + i), "fill2");
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(8'h80 + i), "rw_full");
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, "to8");
        end
        step(1'b1, 1'b1, 8'hC3, "rw8");
        chk("rw8.count", 32'(count), 32'd8);

        // 6: asynchronous reset mid-cycle after 5 writes
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'(8'hE0 + i), "pre_rst");
        end
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst");
        step(1'b1, 1'b0, 8'hA5, "wr_a5");
        step(1'b0, 1'b1, 8'h00, "rd_a5");
        chk("rd_a5.data", 32'(dout), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
